v_adder_mp_seq: RTL and testbench
=================================

# v_adder_mp_seq

Multi-precision add sequencer. It reuses one WIDTH-bit adder across several cycles to add operands of up to 2**IDXW words, supplied least-significant word first. It tracks the carry chain between words, counts words, and enforces operation framing. It sits between a word-serial operand source and a word-serial result sink, with valid/ready handshakes on both sides and one registered output stage.

## Interface
- WIDTH, 8: word width in bits; width of the shared adder.
- IDXW, 2: word-index width; the maximum operation length is MAX_WORDS = 2**IDXW.
- C  in  1  clock; all state changes on the rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- IN_VALID  in  1  operand word present.
- IN_READY  out  1  operand word accepted when IN_VALID && IN_READY.
- IN_FIRST  in  1  word is the least-significant word of a new operation.
- IN_LAST  in  1  word is the most-significant word of the operation.
- A  in  WIDTH  operand A word.
- B  in  WIDTH  operand B word.
- OUT_VALID  out  1  result word present.
- OUT_READY  in  1  sink accepts the result when OUT_VALID && OUT_READY.
- SUM  out  WIDTH  result word.
- CO  out  1  carry out of this word; this is the final carry when OUT_LAST = 1.
- OUT_LAST  out  1  last word of the operation.
- OUT_IDX  out  IDXW  word index within the operation (0 = least-significant word).
- ERR  out  1  framing error flag, qualified by OUT_VALID.

## Operation
- FSM has two states:
  - ST_IDLE: waiting for the first word of an operation.
  - ST_ACTIVE: an operation is in progress.
- Internal registers:
  - carry register `cy`
  - word counter `cnt`, IDXW bits wide
- Carry-in to the adder:
  - 0 in ST_IDLE, regardless of IN_FIRST.
  - 0 in ST_ACTIVE when IN_FIRST = 1.
  - `cy` otherwise.
- Adder: {co, s} = A + B + cin, computed WIDTH+1 bits wide with no truncation before the carry is taken.
- On each accepted input word:
  - Output register loads SUM = s, CO = co, OUT_IDX = index, OUT_LAST and ERR as defined below. OUT_VALID is set to 1.
  - `cy` is set to co.
- Index of the accepted word:
  - 0 if the FSM is in ST_IDLE, or if IN_FIRST = 1.
  - `cnt` otherwise.
- OUT_LAST = IN_LAST || (index == MAX_WORDS-1).
- ERR = (ST_ACTIVE && IN_FIRST) || (index == MAX_WORDS-1 && !IN_LAST).
- Transitions and counter updates on each accepted word:
  - If OUT_LAST = 1: go to ST_IDLE, cnt = 0, cy = 0.
  - Otherwise: go to ST_ACTIVE, cnt = index + 1.
- An IN_FIRST word that arrives while ST_ACTIVE abandons the current operation:
  - No OUT_LAST is emitted for the abandoned operation.
  - The new operation starts at index 0 with carry-in 0, and ERR is set on that word.
- Reaching the length limit without IN_LAST forces termination:
  - The word at index MAX_WORDS-1 is emitted with OUT_LAST = 1 and ERR = 1.
  - The next word starts a new operation.
- Backpressure: IN_READY = !OUT_VALID || OUT_READY (combinational).
- Output hold: while OUT_VALID && !OUT_READY, SUM, CO, OUT_LAST, OUT_IDX and ERR hold stable.
- Output clear: OUT_VALID clears when the output is accepted and no new input is accepted in the same cycle.
- Reset values: OUT_VALID=0, SUM=0, CO=0, OUT_LAST=0, OUT_IDX=0, ERR=0, state=ST_IDLE, cnt=0, cy=0. IN_READY is 1 immediately after reset.

## Timing
- Latency: an input word accepted at edge n appears on the outputs after edge n, i.e. 1 cycle.
- Throughput: 1 word per cycle when OUT_READY is held high.
- Output accept and input accept in the same cycle: the register reloads with the new word and OUT_VALID stays 1, with no bubble.
- CLR asserted mid-operation:
  - All outputs go to their reset values asynchronously, and any partial result is discarded.
  - The first word after CLR deasserts is treated as index 0 with carry-in 0.
- IN_FIRST and IN_LAST both set in ST_IDLE gives a single-word operation: OUT_IDX=0, OUT_LAST=1, ERR=0.
- When IN_VALID = 0, `cy`, `cnt` and the state do not change.

## Structure
- Shared package `v_adders_pkg` contains the ST_IDLE/ST_ACTIVE encodings (1 bit) and the default WIDTH and IDXW values.
- Sub-module `v_adder_cin` is a combinational WIDTH-bit unsigned adder with ports CI, A, B, SUM, CO. The carry is the WIDTH-th bit of the WIDTH+1-bit sum.
- The top level holds the FSM, `cy`, `cnt`, the output register and the handshake logic.

## Test plan
- Single word, WIDTH=8: A=0xFF, B=0x01, IN_FIRST=IN_LAST=1 → next cycle SUM=0x00, CO=1, OUT_LAST=1, OUT_IDX=0, ERR=0.
- Three words, 0x00FFFF + 0x000001, sent as (FF,01), (FF,00), (00,00) back-to-back → SUM 00/00/01, CO 1/1/0, OUT_IDX 0/1/2, OUT_LAST only on the third word, one word per cycle.
- Backpressure: hold OUT_READY=0 for 3 cycles while a word is valid → IN_READY=0, outputs stable, no input consumed. After release, all words are delivered in order with correct carries.
- Mid-operation IN_FIRST: send (FF,01) FIRST, then (01,01) FIRST → second result SUM=0x02, CO=0, OUT_IDX=0, ERR=1.
- Overflow with IDXW=2: send 5 words (80,80) with no IN_LAST → word 3 has OUT_LAST=1, ERR=1. Word 4 has OUT_IDX=0, carry-in 0, SUM=0x00, CO=1.
- CLR pulse during the second word of a three-word operation → OUT_VALID=0 immediately. Next word (01,01) gives SUM=0x02, OUT_IDX=0.

Source files
------------

// File: rtl/v_adders_pkg.sv
// Shared definitions for the multi-precision add sequencer.
//   state_e   : FSM state encoding (1 bit)
//   DEF_WIDTH : default word width of the shared adder
//   DEF_IDXW  : default word-index width (max operation length 2**DEF_IDXW)
package v_adders_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_IDXW  = 2;

endpackage

// File: rtl/v_adder_cin.sv
// Combinational WIDTH-bit unsigned adder with carry in and carry out.
//   CI  : carry in
//   A,B : operand words
//   SUM : low WIDTH bits of A + B + CI
//   CO  : bit WIDTH of the full-width sum
module v_adder_cin #(
   parameter int WIDTH = v_adders_pkg::DEF_WIDTH
) (
   input  logic             CI,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] SUM,
   output logic             CO
);

   // Operands are widened first so the carry is never lost to truncation.
   assign {CO, SUM} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, CI};

endmodule

// File: rtl/v_adder_mp_seq.sv
// Multi-precision add sequencer: adds operands of up to 2**IDXW words,
// least-significant word first, through one shared WIDTH-bit adder, with one
// registered output stage.
//   C, CLR                      : clock, async active-high reset
//   IN_VALID/IN_READY           : operand handshake
//   IN_FIRST/IN_LAST, A, B      : operand word and framing
//   OUT_VALID/OUT_READY         : result handshake
//   SUM, CO, OUT_LAST, OUT_IDX  : result word, its carry, framing, index
//   ERR                         : framing error, qualified by OUT_VALID
//
// state     | meaning
// ST_IDLE   | waiting for the first word of an operation
// ST_ACTIVE | an operation is in progress; cnt holds the next word index
module v_adder_mp_seq
   import v_adders_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDXW  = DEF_IDXW
) (
   input  logic             C,
   input  logic             CLR,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic             IN_FIRST,
   input  logic             IN_LAST,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] SUM,
   output logic             CO,
   output logic             OUT_LAST,
   output logic [IDXW-1:0]  OUT_IDX,
   output logic             ERR
);

   localparam logic [IDXW-1:0] IDX_MAX = '1;

   state_e            state_q, state_d;
   logic [IDXW-1:0]   cnt_q, cnt_d;
   logic              cy_q, cy_d;
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              co_q, co_d;
   logic              last_q, last_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              err_q, err_d;

   logic              accept;
   logic              cin;
   logic [IDXW-1:0]   index;
   logic              word_last;
   logic              word_err;
   logic [WIDTH-1:0]  add_s;
   logic              add_co;

   assign IN_READY = !out_valid_q || OUT_READY;
   assign accept   = IN_VALID && IN_READY;

   v_adder_cin #(.WIDTH(WIDTH)) u_add (
      .CI  (cin),
      .A   (A),
      .B   (B),
      .SUM (add_s),
      .CO  (add_co)
   );

   // State register
   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = word_last ? ST_IDLE : ST_ACTIVE;
      end
   end

   // FSM outputs: per-word carry-in, index and framing for the current input
   always_comb begin
      cin   = 1'b0;
      index = '0;
      if (state_q == ST_ACTIVE && !IN_FIRST) begin
         cin   = cy_q;
         index = cnt_q;
      end
      word_last = IN_LAST || (index == IDX_MAX);
      // A FIRST word mid-operation abandons the old one; running into the
      // length limit without LAST forces termination. Both are flagged.
      word_err  = (state_q == ST_ACTIVE && IN_FIRST) ||
                  (index == IDX_MAX && !IN_LAST);
   end

   // Carry, counter and output register next values
   always_comb begin
      cnt_d       = cnt_q;
      cy_d        = cy_q;
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      co_d        = co_q;
      last_d      = last_q;
      idx_d       = idx_q;
      err_d       = err_q;
      if (accept) begin
         out_valid_d = 1'b1;
         sum_d       = add_s;
         co_d        = add_co;
         last_d      = word_last;
         idx_d       = index;
         err_d       = word_err;
         if (word_last) begin
            cnt_d = '0;
            cy_d  = 1'b0;
         end else begin
            cnt_d = index + IDXW'(1);
            cy_d  = add_co;
         end
      end else if (OUT_READY) begin
         // Data fields keep their last value; only valid drops.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         cnt_q       <= '0;
         cy_q        <= 1'b0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         co_q        <= 1'b0;
         last_q      <= 1'b0;
         idx_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         cy_q        <= cy_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         co_q        <= co_d;
         last_q      <= last_d;
         idx_q       <= idx_d;
         err_q       <= err_d;
      end
   end

   assign OUT_VALID = out_valid_q;
   assign SUM       = sum_q;
   assign CO        = co_q;
   assign OUT_LAST  = last_q;
   assign OUT_IDX   = idx_q;
   assign ERR       = err_q;

endmodule

// File: tb/tb_v_adder_mp_seq.sv
// Directed bench for v_adder_mp_seq (WIDTH=8, IDXW=2).
module tb_v_adder_mp_seq;

   logic       C;
   logic       CLR;
   logic       IN_VALID;
   logic       IN_READY;
   logic       IN_FIRST;
   logic       IN_LAST;
   logic [7:0] A;
   logic [7:0] B;
   logic       OUT_VALID;
   logic       OUT_READY;
   logic [7:0] SUM;
   logic       CO;
   logic       OUT_LAST;
   logic [1:0] OUT_IDX;
   logic       ERR;

   int n_cmp = 0;
   int n_err = 0;

   v_adder_mp_seq #(.WIDTH(8), .IDXW(2)) dut (
      .C         (C),
      .CLR       (CLR),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_FIRST  (IN_FIRST),
      .IN_LAST   (IN_LAST),
      .A         (A),
      .B         (B),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .SUM       (SUM),
      .CO        (CO),
      .OUT_LAST  (OUT_LAST),
      .OUT_IDX   (OUT_IDX),
      .ERR       (ERR)
   );

   initial C = 1'b0;
   always #5 C = ~C;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [7:0] s, input logic co,
                          input logic last, input logic [1:0] idx, input logic err);
      chk({tag, ".valid"}, 32'(OUT_VALID), 32'(1));
      chk({tag, ".sum"},   32'(SUM),       32'(s));
      chk({tag, ".co"},    32'(CO),        32'(co));
      chk({tag, ".last"},  32'(OUT_LAST),  32'(last));
      chk({tag, ".idx"},   32'(OUT_IDX),   32'(idx));
      chk({tag, ".err"},   32'(ERR),       32'(err));
   endtask

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic drive(input logic f, input logic l, input logic [7:0] a, input logic [7:0] b);
      IN_VALID = 1'b1;
      IN_FIRST = f;
      IN_LAST  = l;
      A        = a;
      B        = b;
      tick();
   endtask

   task automatic drop();
      IN_VALID = 1'b0;
      IN_FIRST = 1'b0;
      IN_LAST  = 1'b0;
      A        = '0;
      B        = '0;
   endtask

   initial begin
      CLR       = 1'b1;
      OUT_READY = 1'b1;
      drop();
      #12;
      chk("rst.valid", 32'(OUT_VALID), 32'(0));
      chk("rst.sum",   32'(SUM),       32'(0));
      chk("rst.co",    32'(CO),        32'(0));
      chk("rst.last",  32'(OUT_LAST),  32'(0));
      chk("rst.idx",   32'(OUT_IDX),   32'(0));
      chk("rst.err",   32'(ERR),       32'(0));
      chk("rst.ready", 32'(IN_READY),  32'(1));
      CLR = 1'b0;

      // Single-word operation
      drive(1'b1, 1'b1, 8'hFF, 8'h01);
      drop();
      chk_out("single", 8'h00, 1'b1, 1'b1, 2'd0, 1'b0);
      tick();
      chk("single.drain", 32'(OUT_VALID), 32'(0));

      // Three words back-to-back: 0x00FFFF + 0x000001
      drive(1'b1, 1'b0, 8'hFF, 8'h01);
      chk_out("three.w0", 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
      drive(1'b0, 1'b0, 8'hFF, 8'h00);
      chk_out("three.w1", 8'h00, 1'b1, 1'b0, 2'd1, 1'b0);
      drive(1'b0, 1'b1, 8'h00, 8'h00);
      chk_out("three.w2", 8'h01, 1'b0, 1'b1, 2'd2, 1'b0);
      drop();
      tick();
      chk("three.drain", 32'(OUT_VALID), 32'(0));

      // Backpressure: carry must survive a 3-cycle stall
      OUT_READY = 1'b0;
      drive(1'b1, 1'b0, 8'hFF, 8'h01);
      chk_out("bp.w0", 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
      IN_VALID = 1'b1;
      IN_FIRST = 1'b0;
      IN_LAST  = 1'b1;
      A        = 8'h00;
      B        = 8'h00;
      #1;
      chk("bp.ready0", 32'(IN_READY), 32'(0));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("bp.hold", 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
         chk("bp.ready", 32'(IN_READY), 32'(0));
      end
      OUT_READY = 1'b1;
      #1;
      chk("bp.release", 32'(IN_READY), 32'(1));
      tick();
      chk_out("bp.w1", 8'h01, 1'b0, 1'b1, 2'd1, 1'b0);
      drop();
      tick();
      chk("bp.drain", 32'(OUT_VALID), 32'(0));

      // IN_FIRST mid-operation restarts at index 0 with carry-in 0
      drive(1'b1, 1'b0, 8'hFF, 8'h01);
      chk_out("mid.w0", 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
      drive(1'b1, 1'b0, 8'h01, 8'h01);
      chk_out("mid.restart", 8'h02, 1'b0, 1'b0, 2'd0, 1'b1);
      drive(1'b0, 1'b1, 8'h00, 8'h00);
      chk_out("mid.end", 8'h00, 1'b0, 1'b1, 2'd1, 1'b0);

      // Length limit without IN_LAST
      drive(1'b1, 1'b0, 8'h80, 8'h80);
      chk_out("ovf.w0", 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
      drive(1'b0, 1'b0, 8'h80, 8'h80);
      chk_out("ovf.w1", 8'h01, 1'b1, 1'b0, 2'd1, 1'b0);
      drive(1'b0, 1'b0, 8'h80, 8'h80);
      chk_out("ovf.w2", 8'h01, 1'b1, 1'b0, 2'd2, 1'b0);
      drive(1'b0, 1'b0, 8'h80, 8'h80);
      chk_out("ovf.w3", 8'h01, 1'b1, 1'b1, 2'd3, 1'b1);
      drive(1'b0, 1'b0, 8'h80, 8'h80);
      chk_out("ovf.w4", 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
      drive(1'b0, 1'b1, 8'h00, 8'h00);
      chk_out("ovf.w5", 8'h01, 1'b0, 1'b1, 2'd1, 1'b0);

      // CLR mid-operation
      drive(1'b1, 1'b0, 8'hFF, 8'h01);
      chk_out("clr.w0", 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
      IN_FIRST = 1'b0;
      A        = 8'hFF;
      B        = 8'h00;
      #2;
      CLR = 1'b1;
      #1;
      chk("clr.valid", 32'(OUT_VALID), 32'(0));
      chk("clr.sum",   32'(SUM),       32'(0));
      chk("clr.co",    32'(CO),        32'(0));
      chk("clr.ready", 32'(IN_READY),  32'(1));
      drop();
      #2;
      CLR = 1'b0;
      drive(1'b0, 1'b1, 8'h01, 8'h01);
      chk_out("clr.after", 8'h02, 1'b0, 1'b1, 2'd0, 1'b0);
      drop();
      tick();
      chk("clr.drain", 32'(OUT_VALID), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
